// File: rtl/regfile_wb_arbiter.sv
// Two writeback requesters share the register-file write port. Each one has a FIFO.
// A round-robin arbiter drains the FIFOs into a registered write stage and exports a pending mask.
module regfile_wb_arbiter #(
   parameter int DEPTH = 2,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0_valid,
   input  logic [AW-1:0]        req0_addr,
   input  logic [DW-1:0]        req0_data,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [AW-1:0]        req1_addr,
   input  logic [DW-1:0]        req1_data,
   output logic                 req1_ready,
   output logic                 we3,
   output logic [AW-1:0]        A3,
   output logic [DW-1:0]        WD3,
   output logic [(2**AW)-1:0]   pend_mask,
   output logic                 busy
);
   localparam int PW = $clog2(DEPTH);
   localparam int NR = 2**AW;

   logic [1:0]          in_valid;
   logic [1:0]          ready;
   logic [1:0]          push;
   logic [1:0]          pop;
   logic [1:0]          not_empty;
   logic [1:0][AW-1:0]  in_addr;
   logic [1:0][AW-1:0]  head_addr;
   logic [1:0][DW-1:0]  in_data;
   logic [1:0][DW-1:0]  head_data;
   logic [1:0][NR-1:0]  fifo_pend;
   logic [NR-1:0]       we_mask;
   logic                last_reg;

   assign in_valid   = {req1_valid, req0_valid};
   assign in_addr    = {req1_addr, req0_addr};
   assign in_data    = {req1_data, req0_data};
   assign req0_ready = ready[0];
   assign req1_ready = ready[1];

   for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [AW-1:0] addr_mem [DEPTH];
      logic [DW-1:0] data_mem [DEPTH];
      logic [PW-1:0] wr_ptr_reg;
      logic [PW-1:0] rd_ptr_reg;
      logic [PW:0]   count_reg;
      logic [NR-1:0] pend_local;

      // Readiness looks only at occupancy, so a full FIFO refuses even while it is being popped.
      assign ready[gi]     = rst && (count_reg != (PW+1)'(DEPTH));
      assign push[gi]      = in_valid[gi] && ready[gi] && (in_addr[gi] != '0);
      assign not_empty[gi] = (count_reg != '0);
      assign head_addr[gi] = addr_mem[rd_ptr_reg];
      assign head_data[gi] = data_mem[rd_ptr_reg];
      assign fifo_pend[gi] = pend_local;

      always_ff @(posedge clk) begin
         if (push[gi]) begin
            addr_mem[wr_ptr_reg] <= in_addr[gi];
            data_mem[wr_ptr_reg] <= in_data[gi];
         end
      end

      always_ff @(posedge clk) begin
         if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
         end else begin
            if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push[gi] && !pop[gi])
               count_reg <= count_reg + 1'b1;
            else if (pop[gi] && !push[gi])
               count_reg <= count_reg - 1'b1;
         end
      end

      always_comb begin
         pend_local = '0;
         for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(count_reg))
               pend_local[addr_mem[PW'(rd_ptr_reg + PW'(k))]] = 1'b1;
         end
      end
   end

   // last_reg names the requester granted most recently; reset value 1 favours requester 0.
   assign pop[0] = not_empty[0] && (!not_empty[1] || last_reg);
   assign pop[1] = not_empty[1] && (!not_empty[0] || !last_reg);

   always_ff @(posedge clk) begin
      if (!rst) begin
         we3      <= 1'b0;
         A3       <= '0;
         WD3      <= '0;
         last_reg <= 1'b1;
      end else begin
         we3 <= |pop;
         if (pop[0]) begin
            A3       <= head_addr[0];
            WD3      <= head_data[0];
            last_reg <= 1'b0;
         end else if (pop[1]) begin
            A3       <= head_addr[1];
            WD3      <= head_data[1];
            last_reg <= 1'b1;
         end
      end
   end

   assign we_mask   = we3 ? (NR'(1) << A3) : '0;
   assign pend_mask = rst ? ((fifo_pend[0] | fifo_pend[1] | we_mask) & ~NR'(1)) : '0;
   assign busy      = rst && ((|not_empty) || we3);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter. Directed scenarios are followed by a randomized run.
// Every cycle is compared against a queue-based model of the writeback rules.
module tb_regfile_wb_arbiter;
   localparam int DEPTH = 2;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int NR    = 2**AW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic [AW-1:0] req0_addr = '0, req1_addr = '0;
   logic [DW-1:0] req0_data = '0, req1_data = '0;
   logic          req0_ready, req1_ready, we3, busy;
   logic [AW-1:0] A3;
   logic [DW-1:0] WD3;
   logic [NR-1:0] pend_mask;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .we3(we3), .A3(A3), .WD3(WD3), .pend_mask(pend_mask), .busy(busy)
   );

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   // Model state: buffered writes per requester plus the expected write-port registers.
   ent_t          mq0[$], mq1[$];
   ent_t          in0[$], in1[$];
   logic          m_we;
   logic [AW-1:0] m_a;
   logic [DW-1:0] m_d;
   logic          m_last;
   int            tests = 0;
   int            fails = 0;

   function automatic ent_t mk(input int a, input logic [DW-1:0] d);
      ent_t e;
      e.a = AW'(a);
      e.d = d;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq0.delete();
      mq1.delete();
      m_we   = 1'b0;
      m_a    = '0;
      m_d    = '0;
      m_last = 1'b1;
   endtask

   task automatic cycle(input logic rn, input logic v0, input ent_t e0, input logic v1, input ent_t e1,
                        output logic acc0, output logic acc1);
      logic [NR-1:0] pm;
      logic r0, r1, n0, n1, g0, g1;
      ent_t h;
      rst = rn;
      req0_valid = v0; req0_addr = e0.a; req0_data = e0.d;
      req1_valid = v1; req1_addr = e1.a; req1_data = e1.d;
      #1;
      r0 = rn && (mq0.size() < DEPTH);
      r1 = rn && (mq1.size() < DEPTH);
      pm = '0;
      if (rn) begin
         foreach (mq0[i]) pm[mq0[i].a] = 1'b1;
         foreach (mq1[i]) pm[mq1[i].a] = 1'b1;
         if (m_we) pm[m_a] = 1'b1;
         pm[0] = 1'b0;
      end
      chk("req0_ready", 64'(req0_ready), 64'(r0));
      chk("req1_ready", 64'(req1_ready), 64'(r1));
      chk("we3", 64'(we3), 64'(m_we));
      chk("A3", 64'(A3), 64'(m_a));
      chk("WD3", 64'(WD3), 64'(m_d));
      chk("pend_mask", 64'(pend_mask), 64'(pm));
      chk("busy", 64'(busy), 64'(rn && (mq0.size() != 0 || mq1.size() != 0 || m_we)));
      acc0 = v0 && r0;
      acc1 = v1 && r1;
      if (!rn) begin
         model_reset();
      end else begin
         n0 = (mq0.size() != 0);
         n1 = (mq1.size() != 0);
         g0 = n0 && (!n1 || m_last);
         g1 = n1 && (!n0 || !m_last);
         if (g0) begin
            h = mq0.pop_front(); m_we = 1'b1; m_a = h.a; m_d = h.d; m_last = 1'b0;
         end else if (g1) begin
            h = mq1.pop_front(); m_we = 1'b1; m_a = h.a; m_d = h.d; m_last = 1'b1;
         end else begin
            m_we = 1'b0;
         end
         if (acc0 && e0.a != '0) mq0.push_back(e0);
         if (acc1 && e1.a != '0) mq1.push_back(e1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      logic a0, a1;
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0, a0, a1);
   endtask

   task automatic do_reset();
      logic a0, a1;
      cycle(1'b0, 1'b0, '0, 1'b0, '0, a0, a1);
   endtask

   // Presents the in0/in1 lists, holding each head until accepted, then lets the port drain.
   task automatic drain_lists(input int budget);
      int   n;
      logic a0, a1;
      ent_t e0, e1;
      n = 0;
      while ((in0.size() != 0 || in1.size() != 0) && n < budget) begin
         e0 = (in0.size() != 0) ? in0[0] : '0;
         e1 = (in1.size() != 0) ? in1[0] : '0;
         cycle(1'b1, in0.size() != 0, e0, in1.size() != 0, e1, a0, a1);
         if (a0) void'(in0.pop_front());
         if (a1) void'(in1.pop_front());
         n++;
      end
      chk("drain_budget_left", 64'(in0.size() + in1.size()), 64'(0));
      in0.delete();
      in1.delete();
      idle(5);
   endtask

   initial begin
      logic a0, a1, rn, v0, v1;
      ent_t e0, e1;

      repeat (3) @(posedge clk);
      #1;
      model_reset();
      idle(2);

      // Single write to x5
      in0.push_back(mk(5, 32'h11));
      drain_lists(20);

      // Contention after reset: expect 1,9,2,10,3,11
      do_reset();
      for (int i = 0; i < 3; i++) begin
         in0.push_back(mk(1 + i, 32'h100 + i));
         in1.push_back(mk(9 + i, 32'h200 + i));
      end
      drain_lists(30);

      // Backpressure on req0 while req1 saturates
      for (int i = 0; i < 3; i++) in0.push_back(mk(4 + i, 32'h300 + i));
      for (int i = 0; i < 6; i++) in1.push_back(mk(20 + i, 32'h400 + i));
      drain_lists(40);

      // x0 write is consumed but never committed
      in1.push_back(mk(0, 32'hDEAD));
      drain_lists(10);

      // Reset mid-operation discards buffered writes
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 1'b1, mk(7 + i, 32'h500 + i), 1'b1, mk(12 + i, 32'h600 + i), a0, a1);
      cycle(1'b0, 1'b1, mk(15, 32'h700), 1'b1, mk(16, 32'h701), a0, a1);
      idle(5);

      // Same register written twice back-to-back
      in0.push_back(mk(9, 32'hA1));
      in0.push_back(mk(9, 32'hA2));
      drain_lists(20);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         rn = ($urandom_range(0, 39) != 0);
         v0 = ($urandom_range(0, 2) != 0);
         v1 = ($urandom_range(0, 2) != 0);
         e0 = mk(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, NR - 1)), DW'($urandom));
         e1 = mk(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, NR - 1)), DW'($urandom));
         cycle(rn, v0, e0, v1, e1, a0, a1);
      end
      idle(8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
